// File: rtl/dram_ctrl_pkg.sv
// rtl/dram_ctrl_pkg.sv - shared state encoding, command encodings and timing defaults for dram_ctrl
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PRE_WAIT,
    ACT,
    ACT_WAIT,
    COL,
    COL_WAIT,
    DONE
  } state_t;

  // {rasn, casn}; precharge and activate share a RAS-only encoding and differ on WEn
  localparam logic [1:0] CMD_NOP = 2'b11;
  localparam logic [1:0] CMD_PRE = 2'b01;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_COL = 2'b10;

  localparam logic [3:0] WEN_PRE  = 4'h0;
  localparam logic [3:0] WEN_NONE = 4'hf;

  localparam int T_RP_DEF  = 5;
  localparam int T_RCD_DEF = 5;
  localparam int T_CL_DEF  = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - open-row DRAM command sequencer for single-word read/write requests
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int ROW_W  = 11,
  parameter int COL_W  = 10,
  parameter int ADDR_W = 11,
  parameter int T_RP   = T_RP_DEF,
  parameter int T_RCD  = T_RCD_DEF,
  parameter int T_CL   = T_CL_DEF
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [3:0]             req_wstrb,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   dram_csn,
  output logic                   dram_rasn,
  output logic                   dram_casn,
  output logic [3:0]             dram_wen,
  output logic [ADDR_W-1:0]      dram_a,
  output logic [31:0]            dram_d,
  input  logic [31:0]            dram_q,
  input  logic                   dram_valid
);

  localparam int T_MAX = max3(T_RP, T_RCD, T_CL);
  localparam int CNT_W = $clog2(T_MAX + 1);

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic               row_open;
  logic [ROW_W-1:0]   open_row;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;

  logic [ROW_W-1:0]   row_in;
  logic [COL_W-1:0]   col_in;

  assign row_in = req_addr[ROW_W+COL_W-1:COL_W];
  assign col_in = req_addr[COL_W-1:0];

  // Sequencer: every pin is loaded on the transition into the state that owns it
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state                  <= IDLE;
      counter                <= '0;
      row_open               <= 1'b0;
      open_row               <= '0;
      row_q                  <= '0;
      col_q                  <= '0;
      wstrb_q                <= '0;
      wdata_q                <= '0;
      req_ready              <= 1'b0;
      rsp_valid              <= 1'b0;
      rsp_rdata              <= '0;
      dram_csn               <= 1'b1;
      {dram_rasn, dram_casn} <= CMD_NOP;
      dram_wen               <= WEN_NONE;
      dram_a                 <= '0;
      dram_d                 <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            row_q     <= row_in;
            col_q     <= col_in;
            wstrb_q   <= req_wstrb;
            wdata_q   <= req_wdata;
            dram_csn  <= 1'b0;
            if (row_open && (row_in == open_row)) begin
              state                  <= COL;
              {dram_rasn, dram_casn} <= CMD_COL;
              dram_a                 <= ADDR_W'(col_in);
              dram_wen               <= ~req_wstrb;
              dram_d                 <= req_wdata;
            end else if (row_open) begin
              // the precharge names the row being closed, not the new one
              state                  <= PRE;
              {dram_rasn, dram_casn} <= CMD_PRE;
              dram_wen               <= WEN_PRE;
              dram_a                 <= ADDR_W'(open_row);
            end else begin
              state                  <= ACT;
              {dram_rasn, dram_casn} <= CMD_ACT;
              dram_a                 <= ADDR_W'(row_in);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        PRE: begin
          row_open               <= 1'b0;
          {dram_rasn, dram_casn} <= CMD_NOP;
          dram_wen               <= WEN_NONE;
          counter                <= CNT_W'(T_RP - 2);
          state                  <= PRE_WAIT;
        end
        PRE_WAIT: begin
          if (counter == '0) begin
            state                  <= ACT;
            {dram_rasn, dram_casn} <= CMD_ACT;
            dram_a                 <= ADDR_W'(row_q);
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ACT: begin
          open_row               <= row_q;
          row_open               <= 1'b1;
          {dram_rasn, dram_casn} <= CMD_NOP;
          counter                <= CNT_W'(T_RCD - 2);
          state                  <= ACT_WAIT;
        end
        ACT_WAIT: begin
          if (counter == '0) begin
            state                  <= COL;
            {dram_rasn, dram_casn} <= CMD_COL;
            dram_a                 <= ADDR_W'(col_q);
            dram_wen               <= ~wstrb_q;
            dram_d                 <= wdata_q;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        COL: begin
          {dram_rasn, dram_casn} <= CMD_NOP;
          dram_wen               <= WEN_NONE;
          counter                <= CNT_W'(T_CL - 1);
          state                  <= COL_WAIT;
        end
        COL_WAIT: begin
          // reads finish on the DRAM's valid strobe, writes once D has been sampled
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end
          if (wstrb_q == 4'h0) begin
            if (dram_valid) begin
              rsp_rdata <= dram_q;
              rsp_valid <= 1'b1;
              dram_csn  <= 1'b1;
              state     <= DONE;
            end
          end else if (counter == '0) begin
            rsp_valid <= 1'b1;
            dram_csn  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - directed and random-stream bench for dram_ctrl with a timing-checking DRAM model
module tb_dram_ctrl;

  localparam int T_RP  = 5;
  localparam int T_RCD = 5;
  localparam int T_CL  = 5;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [20:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        dram_csn;
  logic        dram_rasn;
  logic        dram_casn;
  logic [3:0]  dram_wen;
  logic [10:0] dram_a;
  logic [31:0] dram_d;
  logic [31:0] mq = '0;
  logic        mv = 1'b0;
  logic        glitch;
  logic        dram_valid;

  assign dram_valid = mv | glitch;

  dram_ctrl dut (
    .CK         (CK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wstrb  (req_wstrb),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .dram_csn   (dram_csn),
    .dram_rasn  (dram_rasn),
    .dram_casn  (dram_casn),
    .dram_wen   (dram_wen),
    .dram_a     (dram_a),
    .dram_d     (dram_d),
    .dram_q     (mq),
    .dram_valid (dram_valid)
  );

  always #5 CK = ~CK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] wen);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wen[b] ? old[8*b +: 8] : nw[8*b +: 8];
    return r;
  endfunction

  // DRAM model: decodes pins, keeps its own memory, enforces tRP/tRCD/tCL
  logic [31:0] mem [0:4095];
  int          wr_cnt = 0, rd_cnt = 0;
  logic [11:0] w_idx = '0, r_idx = '0;
  logic [3:0]  w_wen = '0;
  logic [10:0] m_row = '0;
  int          pre_c = 0, act_c = 0, cas_c = 0;
  bit          pre_ok = 0, act_ok = 0, cas_ok = 0;
  int          s_pre_cyc = 0, s_act_cyc = 0, s_cas_cyc = 0;
  logic [10:0] s_pre_a = '0, s_act_a = '0, s_cas_a = '0;
  logic [3:0]  s_cas_wen = '0;
  int          ras_cnt = 0, pre_cnt = 0;

  always @(negedge CK) begin
    if (RST) begin
      wr_cnt <= 0;
      rd_cnt <= 0;
      mv     <= 1'b0;
      pre_ok <= 0;
      act_ok <= 0;
      cas_ok <= 0;
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      mv <= 1'b0;
      if (wr_cnt == 1) mem[w_idx] <= merge(mem[w_idx], dram_d, w_wen);
      if (wr_cnt != 0) wr_cnt <= wr_cnt - 1;
      if (rd_cnt == 1) begin
        mv <= 1'b1;
        mq <= mem[r_idx];
      end
      if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      if (!dram_csn) begin
        chk("ras_cas_exclusive", 32'(dram_rasn | dram_casn), 32'd1);
        if (!dram_rasn) begin
          ras_cnt <= ras_cnt + 1;
          if (dram_wen == 4'h0) begin
            pre_c     <= cyc;
            pre_ok    <= 1;
            pre_cnt   <= pre_cnt + 1;
            s_pre_cyc <= cyc;
            s_pre_a   <= dram_a;
          end else begin
            if (pre_ok) chk("tRP", 32'((cyc - pre_c) >= T_RP), 32'd1);
            act_c     <= cyc;
            act_ok    <= 1;
            m_row     <= dram_a;
            s_act_cyc <= cyc;
            s_act_a   <= dram_a;
          end
        end
        if (!dram_casn) begin
          if (act_ok) chk("tRCD", 32'((cyc - act_c) >= T_RCD), 32'd1);
          if (cas_ok) chk("tCL", 32'((cyc - cas_c) >= T_CL), 32'd1);
          cas_c     <= cyc;
          cas_ok    <= 1;
          s_cas_cyc <= cyc;
          s_cas_a   <= dram_a;
          s_cas_wen <= dram_wen;
          if (dram_wen != 4'hf) begin
            wr_cnt <= 4;
            w_idx  <= {m_row[3:0], dram_a[7:0]};
            w_wen  <= dram_wen;
          end else begin
            rd_cnt <= 5;
            r_idx  <= {m_row[3:0], dram_a[7:0]};
          end
        end
      end
    end
  end

  task automatic do_req(input logic [20:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input bit inj, output int hs, output int lat, output logic [31:0] rd,
                        output int busy);
    int n;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge CK);
      n++;
    end
    chk("handshake_wait", 32'(req_ready), 32'd1);
    hs   = cyc;
    busy = 0;
    lat  = -1;
    rd   = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CK);
      glitch = inj && (k == 0);
      if (rsp_valid) begin
        lat = cyc - hs;
        rd  = rsp_rdata;
        break;
      end
      if (req_ready) busy++;
    end
    req_valid = 1'b0;
    glitch    = 1'b0;
    @(negedge CK);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] sb [0:4095];
  int          hs, lat, busy, rc, pc, explat;
  logic [31:0] rd, wd;
  bit          open_m;
  logic [10:0] orow_m, rrow;
  logic [9:0]  rcol;
  logic [3:0]  strb;
  logic [20:0] addr;
  bit          isrd;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) sb[i] = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wstrb = '0;
    req_wdata = '0;
    glitch    = 1'b0;
    RST       = 1'b1;
    repeat (2) @(negedge CK);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_pins", 32'({dram_csn, dram_rasn, dram_casn}), 32'h7);
    chk("rst_wen", 32'(dram_wen), 32'hf);
    chk("rst_a", 32'(dram_a), 32'd0);
    chk("rst_d", dram_d, 32'd0);
    RST = 1'b0;
    @(negedge CK);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // first access, no open row: ACT at +1, CAS at +6, response at +12
    do_req(21'h000400, 4'h0, 32'h0, 0, hs, lat, rd, busy);
    chk("first_act_time", 32'(s_act_cyc - hs), 32'd1);
    chk("first_act_a", 32'(s_act_a), 32'd1);
    chk("first_cas_time", 32'(s_cas_cyc - hs), 32'd6);
    chk("first_cas_a", 32'(s_cas_a), 32'd0);
    chk("first_lat", 32'(lat), 32'd12);
    chk("first_rdata", rd, 32'd0);
    chk("first_busy_accept", 32'(busy), 32'd0);

    // hits on row 1: full write then read back
    rc = ras_cnt;
    do_req(21'h000401, 4'hf, 32'hDEADBEEF, 0, hs, lat, rd, busy);
    chk("hit_wr_lat", 32'(lat), 32'd7);
    chk("hit_wr_wen", 32'(s_cas_wen), 32'h0);
    do_req(21'h000401, 4'h0, 32'h0, 0, hs, lat, rd, busy);
    chk("hit_rd_lat", 32'(lat), 32'd7);
    chk("hit_no_ras", 32'(ras_cnt - rc), 32'd0);
    chk("hit_rd_data", rd, 32'hDEADBEEF);
    chk("hit_busy_accept", 32'(busy), 32'd0);

    // partial write merges into the existing word
    do_req(21'h000401, 4'b0011, 32'h12345678, 0, hs, lat, rd, busy);
    chk("partial_wen", 32'(s_cas_wen), 32'hc);
    chk("partial_lat", 32'(lat), 32'd7);
    do_req(21'h000401, 4'h0, 32'h0, 0, hs, lat, rd, busy);
    chk("partial_rd_data", rd, 32'hDEAD5678);

    // row miss: PRE(row1) -> ACT(row2) -> CAS, with a stray dram_valid during PRE
    pc = pre_cnt;
    do_req(21'h000802, 4'h0, 32'h0, 1, hs, lat, rd, busy);
    chk("miss_pre_count", 32'(pre_cnt - pc), 32'd1);
    chk("miss_pre_time", 32'(s_pre_cyc - hs), 32'd1);
    chk("miss_pre_a", 32'(s_pre_a), 32'd1);
    chk("miss_trp", 32'(s_act_cyc - s_pre_cyc), 32'd5);
    chk("miss_act_a", 32'(s_act_a), 32'd2);
    chk("miss_trcd", 32'(s_cas_cyc - s_act_cyc), 32'd5);
    chk("miss_cas_a", 32'(s_cas_a), 32'd2);
    chk("miss_lat", 32'(lat), 32'd17);
    chk("miss_rdata", rd, 32'd0);

    // reset during ACT_WAIT of a row miss
    req_addr  = 21'h000C00;
    req_wstrb = 4'h0;
    req_wdata = '0;
    req_valid = 1'b1;
    chk("rst_seq_ready", 32'(req_ready), 32'd1);
    hs = cyc;
    while (cyc < hs + 8) @(negedge CK);
    chk("rst_seq_in_act_wait", 32'({dram_csn, dram_rasn, dram_casn}), 32'h3);
    RST       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_mid_csn", 32'(dram_csn), 32'd1);
    chk("rst_mid_cmd", 32'({dram_rasn, dram_casn}), 32'h3);
    chk("rst_mid_wen", 32'(dram_wen), 32'hf);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    @(negedge CK);
    @(negedge CK);
    RST = 1'b0;
    for (int i = 0; i < 4096; i++) sb[i] = '0;
    @(negedge CK);
    chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
    pc = pre_cnt;
    do_req(21'h000C05, 4'b0101, 32'hAABBCCDD, 0, hs, lat, rd, busy);
    chk("post_rst_no_pre", 32'(pre_cnt - pc), 32'd0);
    chk("post_rst_act_time", 32'(s_act_cyc - hs), 32'd1);
    chk("post_rst_lat", 32'(lat), 32'd12);
    chk("post_rst_wen", 32'(s_cas_wen), 32'ha);
    sb[{4'd3, 8'd5}] = merge(sb[{4'd3, 8'd5}], 32'hAABBCCDD, 4'b1010);
    do_req(21'h000C05, 4'h0, 32'h0, 0, hs, lat, rd, busy);
    chk("post_rst_rd_lat", 32'(lat), 32'd7);
    chk("post_rst_rd_data", rd, 32'h00BB00DD);

    // random stream of hits and misses against the scoreboard
    open_m = 1;
    orow_m = 11'd3;
    for (int i = 0; i < 200; i++) begin
      rrow = 11'($urandom_range(0, 3));
      rcol = 10'($urandom_range(0, 15));
      isrd = 1'($urandom_range(0, 1));
      strb = isrd ? 4'h0 : 4'($urandom_range(1, 15));
      wd   = $urandom;
      addr = {rrow, rcol};
      explat = !open_m ? 12 : ((orow_m == rrow) ? 7 : 17);
      do_req(addr, strb, wd, 0, hs, lat, rd, busy);
      chk("rand_lat", 32'(lat), 32'(explat));
      chk("rand_busy_accept", 32'(busy), 32'd0);
      if (isrd) chk("rand_rdata", rd, sb[{rrow[3:0], rcol[7:0]}]);
      else sb[{rrow[3:0], rcol[7:0]}] = merge(sb[{rrow[3:0], rcol[7:0]}], wd, ~strb);
      open_m = 1;
      orow_m = rrow;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Command sequencer sitting directly upstream of the off-chip DRAM model. Drives its CSn/RASn/CASn/WEn/A/D pins.
- Accepts single-word read/write requests from the memory-side bus wrapper over a valid/ready interface.
- Open-row policy: the last activated row stays open. A row hit issues only a column command. A row miss issues precharge, then activate, then column.
- Returns read data, or a write-done pulse, once per request.

Parameters:
- ROW_W, 11, row address width
- COL_W, 10, column address width
- ADDR_W, 11, DRAM A pin width, max(ROW_W,COL_W)
- T_RP, 5, cycles from precharge command to activate command
- T_RCD, 5, cycles from activate command to column command
- T_CL, 5, cycles from column command to completion; also minimum CASn spacing

Ports:
- CK  in  1  clock
- RST  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_addr  in  ROW_W+COL_W  word address: row = upper ROW_W bits, col = lower COL_W bits
- req_wstrb  in  4  byte write strobes, active-high; 0 means read
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data, valid with rsp_valid on reads
- dram_csn  out  1  DRAM CSn
- dram_rasn  out  1  DRAM RASn
- dram_casn  out  1  DRAM CASn
- dram_wen  out  4  DRAM WEn, active-low per byte
- dram_a  out  ADDR_W  DRAM A
- dram_d  out  32  DRAM D
- dram_q  in  32  DRAM Q
- dram_valid  in  1  DRAM VALID

Behaviour:
- One clock and one reset: asynchronous, active-high. All outputs are registered.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0
  - dram_csn=1, dram_rasn=1, dram_casn=1, dram_wen=4'hf, dram_a=0, dram_d=0
  - row_open=0, state=IDLE, counter=0
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, COL, COL_WAIT, DONE.
- IDLE:
  - req_ready=1. A handshake latches addr, wstrb and wdata; req_ready drops the next cycle.
  - Next state: hit (row_open and row==open_row) -> COL; miss with row_open -> PRE; no row open -> ACT.
- PRE (1 cycle):
  - csn=0, rasn=0, casn=1, wen=4'h0, a=open_row. The precharge must carry the currently open row.
  - Clear row_open; go to PRE_WAIT.
- PRE_WAIT: T_RP-1 cycles of rasn=1, wen=4'hf, then ACT.
- ACT (1 cycle):
  - rasn=0, casn=1, wen=4'hf, a=new row. Set open_row and row_open; go to ACT_WAIT.
- ACT_WAIT: T_RCD-1 cycles, then COL.
- COL (1 cycle):
  - rasn=1, casn=0, a={zero-pad, col}, wen=~wstrb, d=wdata.
  - Go to COL_WAIT with counter=T_CL-1.
- COL_WAIT:
  - casn=1, wen=4'hf, csn held 0, d held stable. The DRAM samples D 4 cycles after CAS.
  - Read: leave on the first cycle dram_valid=1 (CAS+5); capture dram_q into rsp_rdata.
  - Write: leave when counter expires (CAS+5).
  - Next state DONE.
- DONE: rsp_valid=1 for exactly one cycle; return to IDLE.
- Chip select: dram_csn=0 from PRE/ACT/COL through COL_WAIT end; 1 in IDLE and DONE.
- Command spacing guarantees:
  - CASn never asserts within T_CL cycles of a previous CAS. Back-to-back hits cost 1 (IDLE) + 1 (COL) + 5 + 1 (DONE) cycles.
  - RASn and CASn are never both low.
  - A row miss adds exactly T_RP+T_RCD cycles.
- Latency from handshake to rsp_valid: hit = 7 cycles; first access (no open row) = 12; miss = 17.
- Boundaries:
  - req_valid held while busy is not accepted; no buffering, depth 1.
  - wstrb partial (e.g. 4'b0101) drives wen=4'b1010 and is treated as a write.
  - dram_valid asserting outside COL_WAIT is ignored.
  - RST mid-sequence returns to IDLE with row_open=0. The DRAM is reset concurrently, so no precharge is owed.
  - The counter is sized to max(T_RP,T_RCD,T_CL).

Decomposition:
- dram_ctrl_pkg holds:
  - state enum typedef
  - localparams for command encodings (NOP, PRE, ACT, COL)
  - default timing constants
- No sub-module. A single FSM plus a shared down-counter is natural.

Test Plan:
- After reset, read addr 21'h000400 (row 1, col 0). Expect:
  - ACT with A=1 at handshake+1
  - CAS with A=0 at +6
  - rsp_valid at +12 with rsp_rdata=0 (memory reset to 0)
- Write 32'hDEADBEEF, wstrb 4'hf, to 21'h000401, then read the same address. Expect:
  - second access is a hit: no RASn low, rsp_valid 7 cycles after its handshake
  - rdata=32'hDEADBEEF
- Write wstrb 4'b0011, data 32'h12345678, over DEADBEEF, then read. Expect rdata=32'hDEAD5678 and dram_wen=4'b1100 on the CAS cycle.
- Row 1 open, read 21'h000802 (row 2). Expect:
  - PRE with A=1, WEn=0
  - ACT with A=2 exactly 5 cycles later
  - CAS 5 cycles after that
  - rsp_valid at handshake+17
- Assert RST during ACT_WAIT. Expect:
  - all DRAM pins return to idle immediately
  - req_ready=1 on the first cycle after release
  - next request takes the no-open-row path (ACT, no PRE)
- Random stream of 200 hits and misses checked against a scoreboard memory model. Expect no CL, tRCD or tRP assertion firings in the DRAM model.
